// File: rtl/x64_adc_pkg.sv
// Shared widths, FSM encoding and phase helpers for the x64 ADC 24-to-64 gearbox.
package x64_adc_pkg;

  localparam int ADC_WORD_W  = 24;
  localparam int BUS_W       = 64;
  localparam int GROUP_WORDS = 4;
  localparam int BLOCK_WORDS = 8;
  localparam int ERRCNT_W    = 16;
  localparam int BLOCK_W     = ADC_WORD_W * BLOCK_WORDS;
  localparam int PHASE_W     = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } gb_state_e;

  // Group boundaries fall on phases 0 and 4 (GROUP_WORDS is a power of two).
  function automatic logic sync_expected(input logic [PHASE_W-1:0] ph);
    return (ph[1:0] == 2'b00);
  endfunction

  // Phases whose acceptance completes one 64-bit output word.
  function automatic logic is_emit_phase(input logic [PHASE_W-1:0] ph);
    return (ph == 3'd2) || (ph == 3'd5) || (ph == 3'd7);
  endfunction

endpackage

// File: rtl/x64_adc_gearbox_phase.sv
// Block alignment FSM: tracks the word phase inside an 8-word block, checks
// group sync placement and reports which phase (if any) accepts the current word.
module x64_adc_gearbox_phase
  import x64_adc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_vld,
  input  logic               i_sync,
  output logic               o_acc,
  output logic [PHASE_W-1:0] o_acc_phase,
  output logic               o_misalign
);

  // state   | meaning
  // ST_IDLE | unaligned, dropping words until a sync-qualified word
  // ST_RUN  | aligned, r_phase is index of next expected word in the block

  gb_state_e          r_state;
  gb_state_e          w_state_nxt;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] w_phase_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    o_acc       = 1'b0;
    o_acc_phase = r_phase;
    o_misalign  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_vld && i_sync) begin
          o_acc       = 1'b1;
          o_acc_phase = '0;
          w_state_nxt = ST_RUN;
          w_phase_nxt = 3'd1;
        end
      end
      ST_RUN: begin
        if (i_vld) begin
          if (i_sync && !sync_expected(r_phase)) begin
            // Early sync: abandon the partial block and restart on this word.
            o_misalign  = 1'b1;
            o_acc       = 1'b1;
            o_acc_phase = '0;
            w_phase_nxt = 3'd1;
          end else if (!i_sync && sync_expected(r_phase)) begin
            o_misalign  = 1'b1;
            w_state_nxt = ST_IDLE;
            w_phase_nxt = '0;
          end else begin
            o_acc       = 1'b1;
            o_acc_phase = r_phase;
            w_phase_nxt = r_phase + 3'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_phase_nxt = '0;
      end
    endcase
  end

endmodule

// File: rtl/x64_adc_gearbox_24to64.sv
// Repacks aligned 8x24-bit ADC blocks into three 64-bit words with sticky misalign
// flag; the saturating error counter exists only with X64_ADC_GEARBOX_ERRCNT_EN.
module x64_adc_gearbox_24to64
  import x64_adc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADC_WORD_W-1:0] din,
  input  logic                  din_vld,
  input  logic                  din_sync,
  output logic [BUS_W-1:0]      dout,
  output logic                  dout_vld,
  output logic                  dout_first,
  output logic                  err_misalign,
  output logic [ERRCNT_W-1:0]   err_count
);

  logic               w_acc;
  logic [PHASE_W-1:0] w_acc_phase;
  logic               w_misalign;
  logic               w_emit;
  logic [BLOCK_W-1:0] r_block;
  logic [BLOCK_W-1:0] w_blk;
  logic [BUS_W-1:0]   w_dout_nxt;
  logic [BUS_W-1:0]   r_dout;
  logic               r_dout_vld;
  logic               r_dout_first;
  logic               r_err_misalign;

  x64_adc_gearbox_phase u_phase (
    .clk         (clk),
    .rst         (rst),
    .i_vld       (din_vld),
    .i_sync      (din_sync),
    .o_acc       (w_acc),
    .o_acc_phase (w_acc_phase),
    .o_misalign  (w_misalign)
  );

  // Block image including the word being accepted this cycle, so the output
  // word completed by that word can be registered on the same edge.
  always_comb begin
    w_blk = r_block;
    for (int k = 0; k < BLOCK_WORDS; k++) begin
      if (w_acc && (w_acc_phase == PHASE_W'(k))) begin
        w_blk[k*ADC_WORD_W +: ADC_WORD_W] = din;
      end
    end
  end

  assign w_emit = w_acc && is_emit_phase(w_acc_phase);

  always_comb begin
    case (w_acc_phase)
      3'd5:    w_dout_nxt = w_blk[2*BUS_W-1:BUS_W];
      3'd7:    w_dout_nxt = w_blk[3*BUS_W-1:2*BUS_W];
      default: w_dout_nxt = w_blk[BUS_W-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_block        <= '0;
      r_dout         <= '0;
      r_dout_vld     <= 1'b0;
      r_dout_first   <= 1'b0;
      r_err_misalign <= 1'b0;
    end else begin
      if (w_acc) begin
        r_block <= w_blk;
      end
      r_dout_vld   <= w_emit;
      r_dout_first <= w_emit && (w_acc_phase == 3'd2);
      if (w_emit) begin
        r_dout <= w_dout_nxt;
      end
      if (w_misalign) begin
        r_err_misalign <= 1'b1;
      end
    end
  end

  assign dout         = r_dout;
  assign dout_vld     = r_dout_vld;
  assign dout_first   = r_dout_first;
  assign err_misalign = r_err_misalign;

`ifdef X64_ADC_GEARBOX_ERRCNT_EN
  logic [ERRCNT_W-1:0] r_err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (w_misalign && (r_err_count != {ERRCNT_W{1'b1}})) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_x64_adc_gearbox_24to64.sv
// Scoreboard bench for x64_adc_gearbox_24to64: word-level reference model feeds an
// expected queue, a negedge monitor pops and compares every dout strobe.
module tb_x64_adc_gearbox_24to64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] din = '0;
  logic        din_vld = 1'b0;
  logic        din_sync = 1'b0;
  logic [63:0] dout;
  logic        dout_vld;
  logic        dout_first;
  logic        err_misalign;
  logic [15:0] err_count;

  x64_adc_gearbox_24to64 dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_vld      (din_vld),
    .din_sync     (din_sync),
    .dout         (dout),
    .dout_vld     (dout_vld),
    .dout_first   (dout_first),
    .err_misalign (err_misalign),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    bit          first;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  bit          m_locked;
  int          m_idx;
  logic [23:0] m_words[8];
  bit          m_err;
  int          m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int exp_count();
`ifdef X64_ADC_GEARBOX_ERRCNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  // Reference: collect words of the current block; the block is the plain
  // concatenation word0 at LSB, cut into 64-bit slices once enough words exist.
  function automatic void model_word(input logic [23:0] w, input bit s);
    logic [191:0] blk;
    int           j;
    if (!m_locked) begin
      if (s) begin
        m_locked   = 1'b1;
        m_words[0] = w;
        m_idx      = 1;
      end
      return;
    end
    if (s != ((m_idx % 4) == 0)) begin
      m_err = 1'b1;
      if (m_cnt < 65535) m_cnt++;
      if (s) begin
        m_words[0] = w;
        m_idx      = 1;
      end else begin
        m_locked = 1'b0;
        m_idx    = 0;
      end
      return;
    end
    m_words[m_idx] = w;
    m_idx++;
    if (m_idx == 3 || m_idx == 6 || m_idx == 8) begin
      blk = '0;
      for (int i = 0; i < m_idx; i++) blk[24*i +: 24] = m_words[i];
      j = (m_idx == 3) ? 0 : (m_idx == 6) ? 1 : 2;
      q.push_back('{data: blk[64*j +: 64], first: (j == 0), cyc: cyc + 1});
    end
    if (m_idx == 8) m_idx = 0;
  endfunction

  task automatic send(input logic [23:0] w, input bit s);
    din      = w;
    din_vld  = 1'b1;
    din_sync = s;
    model_word(w, s);
    @(posedge clk);
    #1;
    din_vld  = 1'b0;
    din_sync = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      din_vld  = 1'b0;
      din      = 24'($urandom);
      din_sync = 1'($urandom);
      @(posedge clk);
      #1;
    end
    din_sync = 1'b0;
  endtask

  task automatic check_err(input string tag);
    check({tag, "_err_misalign"}, 64'(err_misalign), 64'(m_err));
    check({tag, "_err_count"}, 64'(err_count), 64'(exp_count()));
  endtask

  task automatic do_reset(input bit with_word);
    rst      = 1'b1;
    din_vld  = with_word;
    din_sync = with_word;
    din      = 24'hABCDEF;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    din_vld  = 1'b0;
    din_sync = 1'b0;
    m_locked = 1'b0;
    m_idx    = 0;
    m_err    = 1'b0;
    m_cnt    = 0;
    q.delete();
    check("rst_dout", dout, 64'h0);
    check("rst_dout_vld", 64'(dout_vld), 64'h0);
    check("rst_dout_first", 64'(dout_first), 64'h0);
    check("rst_err_misalign", 64'(err_misalign), 64'h0);
    check("rst_err_count", 64'(err_count), 64'h0);
  endtask

  always @(negedge clk) begin
    if (dout_vld) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_dout: got %0h with no word expected (cyc=%0d)", dout, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("dout", dout, e.data);
        check("dout_first", 64'(dout_first), 64'(e.first));
        check("dout_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else if (q.size() > 0 && q[0].cyc < cyc) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL missing_dout: got no strobe expected %0h at cyc %0d", e.data, e.cyc);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);

    // Clean aligned stream
    for (int i = 1; i <= 16; i++) send(24'(i), ((i - 1) % 4) == 0);
    idle(2);
    check_err("clean");

    // Same data with random gaps
    for (int i = 1; i <= 16; i++) begin
      send(24'(i), ((i - 1) % 4) == 0);
      idle($urandom_range(1, 3));
    end
    check_err("gaps");

    // Early sync on phase 3
    send(24'h100, 1'b1);
    send(24'h101, 1'b0);
    send(24'h102, 1'b0);
    send(24'h103, 1'b1);
    for (int i = 1; i < 8; i++) send(24'h200 + 24'(i), (i % 4) == 0);
    idle(2);
    check_err("early_sync");

    // Missing sync on phase 4
    for (int i = 0; i < 4; i++) send(24'h300 + 24'(i), i == 0);
    send(24'h304, 1'b0);
    check_err("missing_sync");
    send(24'h305, 1'b0);
    send(24'h306, 1'b0);
    for (int i = 0; i < 8; i++) send(24'h400 + 24'(i), (i % 4) == 0);
    idle(2);
    check_err("relock");

    // Reset after the phase 5 word, with a word presented during reset
    for (int i = 0; i < 6; i++) send(24'h500 + 24'(i), (i % 4) == 0);
    do_reset(1'b1);
    send(24'h600, 1'b0);
    for (int i = 0; i < 8; i++) send(24'h700 + 24'(i), (i % 4) == 0);
    idle(2);
    check_err("after_rst");

    // Random data, occasional sync errors and gaps
    for (int n = 0; n < 300; n++) begin
      bit s;
      s = m_locked ? ((m_idx % 4) == 0) : 1'b1;
      if ($urandom_range(0, 15) == 0) s = ~s;
      send(24'($urandom), s);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(2);
    check_err("random");

    // Misalign storm to reach counter saturation
    send(24'h0, 1'b1);
    for (int n = 0; n < 65540; n++) send(24'($urandom), 1'b1);
    idle(2);
    check_err("saturate");

    idle(3);
    check("queue_drained", 64'(q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
